// File: rtl/axi_mm_slave_mem_if.sv
// AXI4 memory-mapped bus bundle for axi_mm_slave_mem.
// The slave modport is the memory side; the master modport is the DMA/bench side.
interface axi_mm_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  araddr, arlen, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arlen, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_mm_slave_mem.sv
// AXI4 memory-mapped slave with an internal word memory.
// Independent read (R_IDLE/R_DATA) and write (W_IDLE/W_DATA/W_RESP) state
// machines; FIXED, INCR and WRAP bursts, byte strobes, DECERR for words past
// MEM_DEPTH, SLVERR for illegal burst types / wrap lengths / wlast mismatch.
// Optional macro AXI_MM_SLV_STALL_EN adds LFSR-driven deterministic back-pressure.
module axi_mm_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input logic              axi_aclk,
  input logic              axi_resetn,
  axi_mm_slave_mem_if.slave axi
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] idx;
    idx = a >> BYTE_SH;
    return (idx < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved type or a WRAP with an unsupported length poisons every beat.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok(len));
  endfunction

  // Bad bursts fall back to INCR stepping.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0]            len,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = a + ADDR_WIDTH'(STRB_W);
    mask = (ADDR_WIDTH'(len) << BYTE_SH) | ADDR_WIDTH'(STRB_W - 1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = wrap_ok(len) ? ((a & ~mask) | (inc & mask)) : inc;
      default:     next_addr = inc;
    endcase
  endfunction

  function automatic logic [1:0] resp_of(input logic dec, input logic slv);
    if (dec)      return RESP_DECERR;
    else if (slv) return RESP_SLVERR;
    else          return RESP_OKAY;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and control state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic rst_done;
  logic arready_q;
  logic awready_q;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_load_addr;
  logic [7:0]            r_load_len;
  logic [1:0]            r_load_burst;
  logic [7:0]            r_load_cnt;
  logic                  r_load_ok;

  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [1:0]            w_burst;
  logic [8:0]            w_cnt;
  logic                  w_dec;
  logic                  w_slv;
  logic [1:0]            bresp_q;

  logic                  w_beat;
  logic                  w_in_rng;
  logic                  w_len_bad;
  logic                  w_dec_now;
  logic                  w_slv_now;

  logic arready_w, awready_w, wready_w, rvalid_w, bvalid_w;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // ---------------------------------------------------------------------------
  // Handshake qualification (with optional deterministic back-pressure)
  // ---------------------------------------------------------------------------
`ifdef AXI_MM_SLV_STALL_EN
  logic [7:0] lfsr;
  logic       r_hold;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running from reset.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) lfsr <= 8'hA5;
    else             lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Suppress rvalid for one cycle after a beat load when LFSR bit 3 is low.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_hold <= 1'b0;
    else             r_hold <= r_load ? ~lfsr[3] : 1'b0;
  end

  assign arready_w = arready_q & lfsr[0];
  assign awready_w = awready_q & lfsr[1];
  assign wready_w  = (w_state == W_DATA) & lfsr[2];
  assign rvalid_w  = (r_state == R_DATA) & ~r_hold;
`else
  assign arready_w = arready_q;
  assign awready_w = awready_q;
  assign wready_w  = (w_state == W_DATA);
  assign rvalid_w  = (r_state == R_DATA);
`endif

  assign bvalid_w = (w_state == W_RESP);

  assign ar_hs = axi.arvalid & arready_w;
  assign r_hs  = rvalid_w & axi.rready;
  assign aw_hs = axi.awvalid & awready_w;
  assign w_hs  = axi.wvalid & wready_w;
  assign b_hs  = bvalid_w & axi.bready;

  assign axi.arready = arready_w;
  assign axi.rvalid  = rvalid_w;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.awready = awready_w;
  assign axi.wready  = wready_w;
  assign axi.bvalid  = bvalid_w;
  assign axi.bresp   = bresp_q;

  // Address-ready flops: held low until one cycle after rst_done, low while busy.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rst_done  <= 1'b0;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
    end else begin
      rst_done  <= 1'b1;
      arready_q <= rst_done & (r_next == R_IDLE);
      awready_q <= rst_done & (w_next == W_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // Read state register.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= R_IDLE;
    else             r_state <= r_next;
  end

  // Read next-state and beat-load selection.
  always_comb begin
    r_next       = r_state;
    r_load       = 1'b0;
    r_load_addr  = r_addr;
    r_load_len   = r_len;
    r_load_burst = r_burst;
    r_load_cnt   = r_cnt + 8'd1;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_next       = R_DATA;
          r_load       = 1'b1;
          r_load_addr  = axi.araddr;
          r_load_len   = axi.arlen;
          r_load_burst = axi.arburst;
          r_load_cnt   = 8'd0;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            r_next = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_load_addr = next_addr(r_addr, r_len, r_burst);
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
    r_load_ok = in_range(r_load_addr);
  end

  // Read beat registers: load the next word on every accepted beat.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else if (r_load) begin
      r_addr  <= r_load_addr;
      r_len   <= r_load_len;
      r_burst <= r_load_burst;
      r_cnt   <= r_load_cnt;
      rdata_q <= r_load_ok ? mem[r_load_addr[BYTE_SH +: IDX_W]] : '0;
      rresp_q <= resp_of(!r_load_ok, burst_err(r_load_burst, r_load_len));
      rlast_q <= (r_load_cnt == r_load_len);
    end else if (r_hs && rlast_q) begin
      rlast_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // Write state register.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) w_state <= W_IDLE;
    else             w_state <= w_next;
  end

  // Write next-state and per-beat error evaluation.
  always_comb begin
    w_next    = w_state;
    w_beat    = 1'b0;
    w_in_rng  = in_range(w_addr);
    w_len_bad = axi.wlast ? (w_cnt != {1'b0, w_len}) : (w_cnt == {1'b0, w_len});
    w_dec_now = w_dec | ~w_in_rng;
    w_slv_now = w_slv | w_len_bad;
    case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: begin
        if (w_hs) begin
          w_beat = 1'b1;
          if (axi.wlast) w_next = W_RESP;
        end
      end
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst tracking and sticky error flags.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_dec   <= 1'b0;
      w_slv   <= 1'b0;
      bresp_q <= '0;
    end else begin
      if (aw_hs) begin
        w_addr  <= axi.awaddr;
        w_len   <= axi.awlen;
        w_burst <= axi.awburst;
        w_cnt   <= '0;
        w_dec   <= 1'b0;
        w_slv   <= burst_err(axi.awburst, axi.awlen);
      end
      if (w_beat) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 9'd1;
        w_dec  <= w_dec_now;
        w_slv  <= w_slv_now;
        if (axi.wlast) bresp_q <= resp_of(w_dec_now, w_slv_now);
      end
      if (b_hs) bresp_q <= '0;
    end
  end

  // Byte-lane memory write; not reset so contents survive a bus reset.
  always_ff @(posedge axi_aclk) begin
    if (w_beat && w_in_rng) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[w_addr[BYTE_SH +: IDX_W]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

endmodule
